// File: rtl/gen_bank_pkg.sv
// Shared types for the generation-buffer controller: FSM states, bank index
// type and the helper that picks the bank that is neither read nor displayed.
package gen_bank_pkg;

    localparam int BANK_W    = 2;
    localparam int MAX_BANKS = 3;

    typedef logic [BANK_W-1:0] bank_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_WAIT_BANK = 2'd2
    } state_t;

    typedef struct packed {
        logic  valid;
        bank_t idx;
    } free_t;

    // Lowest-numbered bank that is neither rd nor disp; valid=0 when none is left.
    function automatic free_t free_bank(input bank_t rd, input bank_t disp, input int num_banks);
        free_t f;
        f = '0;
        for (int b = MAX_BANKS - 1; b >= 0; b--) begin
            if (b < num_banks && bank_t'(b) != rd && bank_t'(b) != disp) begin
                f.valid = 1'b1;
                f.idx   = bank_t'(b);
            end
        end
        return f;
    endfunction

endpackage

// File: rtl/gen_bank_mux.sv
// Combinational routing of the compute, next-state and video ports onto the
// per-bank BRAM ports, plus the read-data muxes driven by delayed selects.
module gen_bank_mux
    import gen_bank_pkg::*;
#(
    parameter int X_SIZE    = 1280,
    parameter int Y_WIDTH   = 10,
    parameter int NUM_BANKS = 3
) (
    input  bank_t                         i_rd_sel,
    input  bank_t                         i_wr_sel,
    input  bank_t                         i_disp_sel,
    input  bank_t                         i_rd_sel_d,
    input  bank_t                         i_disp_sel_d,
    input  logic                          i_wr_allow,
    input  logic [Y_WIDTH-1:0]            i_fetch_addr,
    input  logic [Y_WIDTH-1:0]            i_wr_addr,
    input  logic [X_SIZE-1:0]             i_wr_data,
    input  logic                          i_wr_en,
    input  logic [Y_WIDTH-1:0]            i_video_addr,
    input  logic [NUM_BANKS*X_SIZE-1:0]   i_bram_douta,
    input  logic [NUM_BANKS*X_SIZE-1:0]   i_bram_doutb,
    output logic [NUM_BANKS*Y_WIDTH-1:0]  o_bram_addra,
    output logic [NUM_BANKS*X_SIZE-1:0]   o_bram_dina,
    output logic [NUM_BANKS-1:0]          o_bram_wea,
    output logic [NUM_BANKS*Y_WIDTH-1:0]  o_bram_addrb,
    output logic [X_SIZE-1:0]             o_fetch_data,
    output logic [X_SIZE-1:0]             o_video_data
);

    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves a latch.
        o_bram_addra = '0;
        o_bram_dina  = '0;
        o_bram_wea   = '0;
        o_bram_addrb = '0;
        o_fetch_data = '0;
        o_video_data = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            // The read bank owns port A while the write bank is parked on it.
            if (bank_t'(b) == i_rd_sel) begin
                o_bram_addra[b*Y_WIDTH +: Y_WIDTH] = i_fetch_addr;
            end else if (bank_t'(b) == i_wr_sel) begin
                o_bram_addra[b*Y_WIDTH +: Y_WIDTH] = i_wr_addr;
                o_bram_dina[b*X_SIZE +: X_SIZE]    = i_wr_data;
                o_bram_wea[b]                      = i_wr_en & i_wr_allow;
            end
            if (bank_t'(b) == i_disp_sel) begin
                o_bram_addrb[b*Y_WIDTH +: Y_WIDTH] = i_video_addr;
            end
            if (bank_t'(b) == i_rd_sel_d) begin
                o_fetch_data = i_bram_douta[b*X_SIZE +: X_SIZE];
            end
            if (bank_t'(b) == i_disp_sel_d) begin
                o_video_data = i_bram_doutb[b*X_SIZE +: X_SIZE];
            end
        end
    end

endmodule

// File: rtl/gen_bank_controller.sv
// Generation-buffer controller: sequences engine generations and rotates the
// read / write / display bank pointers so the displayed bank never tears.
module gen_bank_controller
    import gen_bank_pkg::*;
#(
    parameter int X_SIZE    = 1280,
    parameter int Y_SIZE    = 720,
    parameter int Y_WIDTH   = 10,
    parameter int NUM_BANKS = 3,
    parameter int GEN_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          mode,
    input  logic                          step,
    input  logic                          frame_start,
    output logic                          gen_start,
    input  logic                          gen_done,
    input  logic [Y_WIDTH-1:0]            fetch_addr,
    output logic [X_SIZE-1:0]             fetch_data,
    input  logic [Y_WIDTH-1:0]            wr_addr,
    input  logic [X_SIZE-1:0]             wr_data,
    input  logic                          wr_en,
    input  logic [Y_WIDTH-1:0]            video_addr,
    output logic [X_SIZE-1:0]             video_data,
    output logic [NUM_BANKS*Y_WIDTH-1:0]  bram_addra,
    output logic [NUM_BANKS*X_SIZE-1:0]   bram_dina,
    output logic [NUM_BANKS-1:0]          bram_wea,
    input  logic [NUM_BANKS*X_SIZE-1:0]   bram_douta,
    output logic [NUM_BANKS*Y_WIDTH-1:0]  bram_addrb,
    input  logic [NUM_BANKS*X_SIZE-1:0]   bram_doutb,
    output logic [1:0]                    rd_bank,
    output logic [1:0]                    wr_bank,
    output logic [1:0]                    disp_bank,
    output logic [GEN_WIDTH-1:0]          gen_count,
    output logic                          busy
);

    state_t                r_state, w_state_next;
    bank_t                 r_rd, r_wr, r_disp, r_rd_d, r_disp_d;
    bank_t                 w_rd_next, w_wr_next, w_disp_next;
    logic                  r_gen_start, w_gen_start_next, w_commit, w_wr_allow;
    logic [GEN_WIDTH-1:0]  r_gen_count;
    free_t                 w_free;

    always_comb begin
        w_state_next     = r_state;
        w_rd_next        = r_rd;
        w_wr_next        = r_wr;
        w_disp_next      = frame_start ? r_rd : r_disp;
        w_gen_start_next = 1'b0;
        w_commit         = 1'b0;
        // Free bank is judged against the post-commit read and display pointers.
        w_free           = free_bank(r_wr, w_disp_next, NUM_BANKS);
        case (r_state)
            ST_IDLE: begin
                if (!mode || step) begin
                    w_gen_start_next = 1'b1;
                    w_state_next     = ST_RUN;
                end
            end
            ST_RUN: begin
                if (gen_done) begin
                    w_commit  = 1'b1;
                    w_rd_next = r_wr;
                    if (w_free.valid) begin
                        w_wr_next    = w_free.idx;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_WAIT_BANK;
                    end
                end
            end
            ST_WAIT_BANK: begin
                if (frame_start) begin
                    w_wr_next    = r_disp;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rd        <= bank_t'(0);
            r_wr        <= bank_t'(1);
            r_disp      <= bank_t'(0);
            r_rd_d      <= bank_t'(0);
            r_disp_d    <= bank_t'(0);
            r_gen_start <= 1'b0;
            r_gen_count <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the same pre-edge values.
            r_state     <= w_state_next;
            r_rd        <= w_rd_next;
            r_wr        <= w_wr_next;
            r_disp      <= w_disp_next;
            r_rd_d      <= r_rd;
            r_disp_d    <= r_disp;
            r_gen_start <= w_gen_start_next;
            if (w_commit) begin
                r_gen_count <= r_gen_count + 1'b1;
            end
        end
    end

    // Rows beyond the generation height are never written.
    assign w_wr_allow = (r_state == ST_RUN) && (int'(wr_addr) < Y_SIZE);

    gen_bank_mux #(
        .X_SIZE    (X_SIZE),
        .Y_WIDTH   (Y_WIDTH),
        .NUM_BANKS (NUM_BANKS)
    ) u_mux (
        .i_rd_sel     (r_rd),
        .i_wr_sel     (r_wr),
        .i_disp_sel   (r_disp),
        .i_rd_sel_d   (r_rd_d),
        .i_disp_sel_d (r_disp_d),
        .i_wr_allow   (w_wr_allow),
        .i_fetch_addr (fetch_addr),
        .i_wr_addr    (wr_addr),
        .i_wr_data    (wr_data),
        .i_wr_en      (wr_en),
        .i_video_addr (video_addr),
        .i_bram_douta (bram_douta),
        .i_bram_doutb (bram_doutb),
        .o_bram_addra (bram_addra),
        .o_bram_dina  (bram_dina),
        .o_bram_wea   (bram_wea),
        .o_bram_addrb (bram_addrb),
        .o_fetch_data (fetch_data),
        .o_video_data (video_data)
    );

    assign rd_bank   = r_rd;
    assign wr_bank   = r_wr;
    assign disp_bank = r_disp;
    assign gen_start = r_gen_start;
    assign gen_count = r_gen_count;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_gen_bank_controller.sv
// Bench for gen_bank_controller: a 3-bank instance with behavioural BRAMs and a
// 2-bank instance for the wait-for-frame path, checked against a generation-level model.
module tb_gen_bank_controller;

    localparam int X  = 16;
    localparam int YS = 8;
    localparam int YW = 3;
    localparam int GW = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // 3-bank instance
    logic            a_mode, a_step, a_frame_start, a_gen_done, a_wr_en;
    logic [YW-1:0]   a_fetch_addr, a_wr_addr, a_video_addr;
    logic [X-1:0]    a_wr_data, a_fetch_data, a_video_data;
    logic            a_gen_start, a_busy;
    logic [3*YW-1:0] a_addra, a_addrb;
    logic [3*X-1:0]  a_dina, a_douta, a_doutb;
    logic [2:0]      a_wea;
    logic [1:0]      a_rd, a_wr, a_disp;
    logic [GW-1:0]   a_gc;

    // 2-bank instance
    logic            b_mode, b_step, b_frame_start, b_gen_done, b_wr_en;
    logic [YW-1:0]   b_fetch_addr, b_wr_addr, b_video_addr;
    logic [X-1:0]    b_wr_data, b_fetch_data, b_video_data;
    logic            b_gen_start, b_busy;
    logic [2*YW-1:0] b_addra, b_addrb;
    logic [2*X-1:0]  b_dina, b_dout_zero;
    logic [1:0]      b_wea;
    logic [1:0]      b_rd, b_wr, b_disp;
    logic [GW-1:0]   b_gc;

    assign b_dout_zero = '0;

    gen_bank_controller #(.X_SIZE(X), .Y_SIZE(YS), .Y_WIDTH(YW), .NUM_BANKS(3), .GEN_WIDTH(GW)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(a_mode), .step(a_step), .frame_start(a_frame_start),
        .gen_start(a_gen_start), .gen_done(a_gen_done), .fetch_addr(a_fetch_addr),
        .fetch_data(a_fetch_data), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_en(a_wr_en),
        .video_addr(a_video_addr), .video_data(a_video_data), .bram_addra(a_addra),
        .bram_dina(a_dina), .bram_wea(a_wea), .bram_douta(a_douta), .bram_addrb(a_addrb),
        .bram_doutb(a_doutb), .rd_bank(a_rd), .wr_bank(a_wr), .disp_bank(a_disp),
        .gen_count(a_gc), .busy(a_busy)
    );

    gen_bank_controller #(.X_SIZE(X), .Y_SIZE(YS), .Y_WIDTH(YW), .NUM_BANKS(2), .GEN_WIDTH(GW)) dut2 (
        .clk(clk), .rst_n(rst_n), .mode(b_mode), .step(b_step), .frame_start(b_frame_start),
        .gen_start(b_gen_start), .gen_done(b_gen_done), .fetch_addr(b_fetch_addr),
        .fetch_data(b_fetch_data), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_en(b_wr_en),
        .video_addr(b_video_addr), .video_data(b_video_data), .bram_addra(b_addra),
        .bram_dina(b_dina), .bram_wea(b_wea), .bram_douta(b_dout_zero), .bram_addrb(b_addrb),
        .bram_doutb(b_dout_zero), .rd_bank(b_rd), .wr_bank(b_wr), .disp_bank(b_disp),
        .gen_count(b_gc), .busy(b_busy)
    );

    // Behavioural dual-port BRAMs for the 3-bank instance, 1-cycle read-first.
    logic [X-1:0] mem [3][YS];
    always @(posedge clk) begin
        for (int b = 0; b < 3; b++) begin
            if (a_wea[b]) mem[b][a_addra[b*YW +: YW]] <= a_dina[b*X +: X];
            a_douta[b*X +: X] <= mem[b][a_addra[b*YW +: YW]];
            a_doutb[b*X +: X] <= mem[b][a_addrb[b*YW +: YW]];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic mode_a, input logic mode_b);
        rst_n = 1'b0;
        a_mode = mode_a; a_step = 0; a_frame_start = 0; a_gen_done = 0; a_wr_en = 0;
        a_fetch_addr = '0; a_wr_addr = '0; a_video_addr = '0; a_wr_data = '0;
        b_mode = mode_b; b_step = 0; b_frame_start = 0; b_gen_done = 0; b_wr_en = 0;
        b_fetch_addr = '0; b_wr_addr = '0; b_video_addr = '0; b_wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(1'b1, 1'b1);
        n_checks++;
        if ({a_rd, a_wr, a_disp} !== 6'b00_01_00) begin
            n_errors++; $display("FAIL reset_ptrs3 got %h want %h", {a_rd, a_wr, a_disp}, 6'b00_01_00);
        end
        n_checks++;
        if ({a_gc, a_gen_start, a_busy, a_wea} !== '0) begin
            n_errors++; $display("FAIL reset_ctl3 got %h want 0", {a_gc, a_gen_start, a_busy, a_wea});
        end
        n_checks++;
        if ({b_rd, b_wr, b_disp, b_gc, b_gen_start, b_busy, b_wea} !== {6'b00_01_00, {(GW+4){1'b0}}}) begin
            n_errors++; $display("FAIL reset_all2 got %h", {b_rd, b_wr, b_disp, b_gc, b_gen_start, b_busy, b_wea});
        end
    endtask

    task automatic test_two_bank();
        int cnt;
        do_reset(1'b1, 1'b0);
        tick();
        n_checks++;
        if ({b_gen_start, b_busy} !== 2'b11) begin
            n_errors++; $display("FAIL tb_first_start got %b want 11", {b_gen_start, b_busy});
        end
        tick();
        n_checks++;
        if (b_gen_start !== 1'b0) begin
            n_errors++; $display("FAIL tb_start_pulse got %b want 0", b_gen_start);
        end
        b_gen_done = 1; tick(); b_gen_done = 0;
        n_checks++;
        if ({b_rd, b_wr, b_disp, b_busy, b_gc} !== {6'b01_01_00, 1'b1, 16'd1}) begin
            n_errors++; $display("FAIL tb_commit_wait got %h want %h", {b_rd, b_wr, b_disp, b_busy, b_gc}, {6'b01_01_00, 1'b1, 16'd1});
        end
        cnt = 0;
        repeat (5) begin tick(); if (b_gen_start) cnt++; end
        n_checks++;
        if (cnt != 0 || b_busy !== 1'b1) begin
            n_errors++; $display("FAIL tb_wait_hold got starts=%0d busy=%b want 0/1", cnt, b_busy);
        end
        b_frame_start = 1; tick(); b_frame_start = 0;
        n_checks++;
        if ({b_rd, b_wr, b_disp, b_busy} !== {6'b01_00_01, 1'b0}) begin
            n_errors++; $display("FAIL tb_frame_flip got %h want %h", {b_rd, b_wr, b_disp, b_busy}, {6'b01_00_01, 1'b0});
        end
        tick();
        n_checks++;
        if (b_gen_start !== 1'b1) begin
            n_errors++; $display("FAIL tb_next_start got %b want 1", b_gen_start);
        end
        b_gen_done = 1; b_frame_start = 1; tick(); b_gen_done = 0; b_frame_start = 0;
        n_checks++;
        if ({b_rd, b_wr, b_disp, b_busy, b_gc} !== {6'b00_00_01, 1'b1, 16'd2}) begin
            n_errors++; $display("FAIL tb_simul2 got %h want %h", {b_rd, b_wr, b_disp, b_busy, b_gc}, {6'b00_00_01, 1'b1, 16'd2});
        end
        b_frame_start = 1; tick(); b_frame_start = 0;
        n_checks++;
        if ({b_rd, b_wr, b_disp, b_busy} !== {6'b00_01_00, 1'b0}) begin
            n_errors++; $display("FAIL tb_release2 got %h want %h", {b_rd, b_wr, b_disp, b_busy}, {6'b00_01_00, 1'b0});
        end
    endtask

    task automatic test_three_bank();
        do_reset(1'b0, 1'b1);
        tick();
        a_gen_done = 1; tick(); a_gen_done = 0;
        n_checks++;
        if ({a_rd, a_wr, a_disp, a_busy, a_gc} !== {6'b01_10_00, 1'b0, 16'd1}) begin
            n_errors++; $display("FAIL th_commit1 got %h want %h", {a_rd, a_wr, a_disp, a_busy, a_gc}, {6'b01_10_00, 1'b0, 16'd1});
        end
        tick();
        n_checks++;
        if (a_gen_start !== 1'b1) begin
            n_errors++; $display("FAIL th_restart got %b want 1", a_gen_start);
        end
        a_gen_done = 1; tick(); a_gen_done = 0;
        n_checks++;
        if ({a_rd, a_wr, a_disp, a_busy, a_gc} !== {6'b10_01_00, 1'b0, 16'd2}) begin
            n_errors++; $display("FAIL th_commit2 got %h want %h", {a_rd, a_wr, a_disp, a_busy, a_gc}, {6'b10_01_00, 1'b0, 16'd2});
        end
    endtask

    task automatic test_pause();
        int cnt;
        do_reset(1'b1, 1'b1);
        cnt = 0;
        repeat (100) begin tick(); if (a_gen_start) cnt++; end
        n_checks++;
        if (cnt != 0 || a_busy !== 1'b0) begin
            n_errors++; $display("FAIL pause_idle got starts=%0d busy=%b want 0/0", cnt, a_busy);
        end
        a_step = 1; tick(); a_step = 0;
        cnt = a_gen_start ? 1 : 0;
        repeat (3) begin tick(); if (a_gen_start) cnt++; end
        a_step = 1; tick(); a_step = 0;
        if (a_gen_start) cnt++;
        repeat (10) begin tick(); if (a_gen_start) cnt++; end
        n_checks++;
        if (cnt != 1 || a_busy !== 1'b1) begin
            n_errors++; $display("FAIL pause_step got starts=%0d busy=%b want 1/1", cnt, a_busy);
        end
        a_gen_done = 1; tick(); a_gen_done = 0;
        n_checks++;
        if ({a_gc, a_busy} !== {16'd1, 1'b0}) begin
            n_errors++; $display("FAIL pause_commit got %h want %h", {a_gc, a_busy}, {16'd1, 1'b0});
        end
        cnt = 0;
        repeat (20) begin tick(); if (a_gen_start) cnt++; end
        n_checks++;
        if (cnt != 0) begin
            n_errors++; $display("FAIL pause_hold got starts=%0d want 0", cnt);
        end
    endtask

    task automatic test_routing();
        do_reset(1'b1, 1'b1);
        a_wr_en = 1; a_wr_addr = 3'd3; a_wr_data = 16'hFFFF; #1;
        n_checks++;
        if (a_wea !== 3'b000) begin
            n_errors++; $display("FAIL route_idle_we got %b want 000", a_wea);
        end
        a_wr_en = 0;
        a_step = 1; tick(); a_step = 0;
        a_wr_en = 1; a_wr_addr = 3'd5; a_wr_data = 16'hA5A5; #1;
        n_checks++;
        if ({a_wea, a_addra[YW +: YW], a_dina[X +: X]} !== {3'b010, 3'd5, 16'hA5A5}) begin
            n_errors++; $display("FAIL route_write got %h want %h", {a_wea, a_addra[YW +: YW], a_dina[X +: X]}, {3'b010, 3'd5, 16'hA5A5});
        end
        tick(); a_wr_en = 0;
        a_gen_done = 1; tick(); a_gen_done = 0;
        a_fetch_addr = 3'd5; a_video_addr = 3'd5;
        tick();
        n_checks++;
        if (a_fetch_data !== 16'hA5A5) begin
            n_errors++; $display("FAIL route_fetch got %h want a5a5", a_fetch_data);
        end
        n_checks++;
        if (a_video_data === 16'hA5A5) begin
            n_errors++; $display("FAIL route_video_early got %h want old bank data", a_video_data);
        end
        a_frame_start = 1; tick(); a_frame_start = 0;
        tick();
        n_checks++;
        if (a_video_data !== 16'hA5A5) begin
            n_errors++; $display("FAIL route_video got %h want a5a5", a_video_data);
        end
    endtask

    task automatic test_simul();
        do_reset(1'b0, 1'b1);
        tick();
        a_gen_done = 1; tick(); a_gen_done = 0;
        tick();
        a_gen_done = 1; a_frame_start = 1; tick(); a_gen_done = 0; a_frame_start = 0;
        n_checks++;
        if ({a_rd, a_wr, a_disp, a_gc} !== {6'b10_00_01, 16'd2}) begin
            n_errors++; $display("FAIL simul3 got %h want %h", {a_rd, a_wr, a_disp, a_gc}, {6'b10_00_01, 16'd2});
        end
        n_checks++;
        if (a_wr === a_rd || a_wr === a_disp) begin
            n_errors++; $display("FAIL simul3_inv got wr=%0d rd=%0d disp=%0d want distinct", a_wr, a_rd, a_disp);
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset(1'b0, 1'b1);
        tick();
        a_gen_done = 1; tick(); a_gen_done = 0;
        tick();
        a_wr_en = 1; a_wr_addr = 3'd2;
        #2;
        a_mode = 1; rst_n = 0;
        #1;
        n_checks++;
        if ({a_rd, a_wr, a_disp, a_gc, a_gen_start, a_busy, a_wea} !== {6'b00_01_00, {(GW+5){1'b0}}}) begin
            n_errors++; $display("FAIL midrun_reset got %h", {a_rd, a_wr, a_disp, a_gc, a_gen_start, a_busy, a_wea});
        end
        @(posedge clk); #1;
        rst_n = 1; a_wr_en = 0;
        a_gen_done = 1; tick(); a_gen_done = 0;
        n_checks++;
        if ({a_rd, a_wr, a_disp, a_gc, a_busy} !== {6'b00_01_00, {(GW+1){1'b0}}}) begin
            n_errors++; $display("FAIL midrun_late_done got %h", {a_rd, a_wr, a_disp, a_gc, a_busy});
        end
    endtask

    // Random traffic against a model that tracks generation images rather than banks.
    task automatic test_random();
        int m_rd, m_wr, m_disp, m_gc, old_rd, old_disp, eng_row;
        bit m_run, m_wait, exp_gs, eng_on, chk_f, chk_v;
        logic [X-1:0] img_w [YS];
        logic [X-1:0] img_r [YS];
        logic [X-1:0] img_d [YS];
        bit ok_w [YS];
        bit ok_r [YS];
        bit ok_d [YS];
        logic [X-1:0] exp_f, exp_v;
        do_reset(1'b0, 1'b1);
        m_rd = 0; m_wr = 1; m_disp = 0; m_gc = 0;
        m_run = 0; m_wait = 0; exp_gs = 0; eng_on = 0; eng_row = 0;
        ok_w = '{default: 0}; ok_r = '{default: 0}; ok_d = '{default: 0};
        for (int cyc = 0; cyc < 600; cyc++) begin
            if ($urandom_range(0, 63) == 0) a_mode = ~a_mode;
            a_step        = ($urandom_range(0, 15) == 0);
            a_frame_start = ($urandom_range(0, 9) == 0);
            a_fetch_addr  = YW'($urandom_range(0, YS - 1));
            a_video_addr  = YW'($urandom_range(0, YS - 1));
            a_wr_addr     = YW'($urandom_range(0, YS - 1));
            a_wr_data     = X'($urandom);
            a_gen_done    = 0;
            a_wr_en       = 0;
            if (eng_on) begin
                if (eng_row < YS) begin
                    a_wr_en = 1; a_wr_addr = YW'(eng_row); eng_row++;
                end else if ($urandom_range(0, 2) == 0) begin
                    a_gen_done = 1; eng_on = 0;
                end
            end else begin
                a_wr_en    = ($urandom_range(0, 7) == 0);
                a_gen_done = ($urandom_range(0, 15) == 0);
            end
            chk_f = ok_r[a_fetch_addr]; exp_f = img_r[a_fetch_addr];
            chk_v = ok_d[a_video_addr]; exp_v = img_d[a_video_addr];
            tick();
            if (m_run && a_wr_en) begin
                img_w[a_wr_addr] = a_wr_data; ok_w[a_wr_addr] = 1;
            end
            old_rd = m_rd; old_disp = m_disp; exp_gs = 0;
            if (a_frame_start) begin
                m_disp = old_rd; img_d = img_r; ok_d = ok_r;
            end
            if (m_run && a_gen_done) begin
                m_run = 0; m_gc++;
                m_rd = m_wr; img_r = img_w; ok_r = ok_w;
                m_wait = 1;
                for (int b = 2; b >= 0; b--) begin
                    if (b != m_rd && b != m_disp) begin m_wr = b; m_wait = 0; end
                end
            end else if (m_wait && a_frame_start) begin
                m_wr = old_disp; m_wait = 0;
            end else if (!m_run && !m_wait && (!a_mode || a_step)) begin
                m_run = 1; exp_gs = 1; ok_w = '{default: 0};
            end
            n_checks++;
            if ({a_rd, a_wr, a_disp} !== {2'(m_rd), 2'(m_wr), 2'(m_disp)}) begin
                n_errors++; $display("FAIL rand_ptrs cyc %0d got %h want %h", cyc, {a_rd, a_wr, a_disp}, {2'(m_rd), 2'(m_wr), 2'(m_disp)});
            end
            n_checks++;
            if ({a_gc, a_gen_start, a_busy} !== {GW'(m_gc), exp_gs, m_run || m_wait}) begin
                n_errors++; $display("FAIL rand_ctl cyc %0d got %h want %h", cyc, {a_gc, a_gen_start, a_busy}, {GW'(m_gc), exp_gs, m_run || m_wait});
            end
            n_checks++;
            if (a_wr === a_rd || a_wr === a_disp) begin
                n_errors++; $display("FAIL rand_inv cyc %0d got wr=%0d rd=%0d disp=%0d", cyc, a_wr, a_rd, a_disp);
            end
            if (chk_f) begin
                n_checks++;
                if (a_fetch_data !== exp_f) begin
                    n_errors++; $display("FAIL rand_fetch cyc %0d got %h want %h", cyc, a_fetch_data, exp_f);
                end
            end
            if (chk_v) begin
                n_checks++;
                if (a_video_data !== exp_v) begin
                    n_errors++; $display("FAIL rand_video cyc %0d got %h want %h", cyc, a_video_data, exp_v);
                end
            end
            if (exp_gs) begin eng_on = 1; eng_row = 0; end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_two_bank();
        test_three_bank();
        test_pause();
        test_routing();
        test_simul();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
